// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Byte-oriented SPI peripheral. SCLK, CS_n and MOSI are oversampled in the
// i_CLK domain through equal-depth synchroniser chains, so MOSI keeps its
// alignment with SCLK. Received bytes are assembled MSB-first. Transmit bytes
// come from a one-byte holding buffer and are shifted out MSB-first on MISO.
// i_CLK must run at least 8x faster than SCLK.
//
// Parameters
//   SPI_MODE     CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
//   DEFAULT_TX   byte sent when the holding buffer is empty at a byte-load point
//   SYNC_STAGES  synchroniser depth (>= 2)
//
// Ports
//   i_CLK          system clock, rising edge
//   i_RST          asynchronous reset, active high
//   i_SPI_Clk      SCLK from the master (asynchronous)
//   i_SPI_CS_n     chip select, active low (asynchronous)
//   i_SPI_MOSI     serial data in (asynchronous)
//   o_SPI_MISO     serial data out
//   o_SPI_MISO_En  MISO output enable, high while the slave is selected
//   i_TX_Byte      next byte to transmit
//   i_TX_DV        one-cycle strobe, i_TX_Byte valid
//   o_TX_Ready     holding buffer empty, i_TX_DV will be accepted
//   o_TX_Underrun  one-cycle pulse, a byte-load point found the buffer empty
//   o_RX_Byte      last complete received byte
//   o_RX_DV        one-cycle pulse, o_RX_Byte updated
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int         SPI_MODE    = 0,
    parameter logic [7:0] DEFAULT_TX  = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_TX_Underrun,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV
);

    localparam logic CPOL = ((SPI_MODE / 2) % 2) == 1;
    localparam logic CPHA = (SPI_MODE % 2) == 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. All three chains have the same depth so a MOSI
    // bit set up against an SCLK edge arrives in the same cycle as the edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_pipe_reg;
    logic [SYNC_STAGES-1:0] cs_pipe_reg;
    logic [SYNC_STAGES-1:0] mosi_pipe_reg;
    logic                   sclk_old_reg;
    logic                   cs_old_reg;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            sclk_pipe_reg <= {SYNC_STAGES{CPOL}};
            cs_pipe_reg   <= {SYNC_STAGES{1'b1}};
            mosi_pipe_reg <= '0;
            sclk_old_reg  <= CPOL;
            cs_old_reg    <= 1'b1;
        end else begin
            sclk_pipe_reg <= {sclk_pipe_reg[SYNC_STAGES-2:0], i_SPI_Clk};
            cs_pipe_reg   <= {cs_pipe_reg[SYNC_STAGES-2:0], i_SPI_CS_n};
            mosi_pipe_reg <= {mosi_pipe_reg[SYNC_STAGES-2:0], i_SPI_MOSI};
            sclk_old_reg  <= sclk_pipe_reg[SYNC_STAGES-1];
            cs_old_reg    <= cs_pipe_reg[SYNC_STAGES-1];
        end
    end

    logic sclk_sync;
    logic cs_sync;
    logic mosi_sync;
    assign sclk_sync = sclk_pipe_reg[SYNC_STAGES-1];
    assign cs_sync   = cs_pipe_reg[SYNC_STAGES-1];
    assign mosi_sync = mosi_pipe_reg[SYNC_STAGES-1];

    // Edge detection: synchronised level versus the one-cycle-old copy.
    logic leading_edge;
    logic trailing_edge;
    logic sample_edge;
    logic shift_edge;
    logic cs_fall;
    logic cs_rise;

    assign leading_edge  = (sclk_old_reg == CPOL) && (sclk_sync != CPOL);
    assign trailing_edge = (sclk_old_reg != CPOL) && (sclk_sync == CPOL);
    assign sample_edge   = CPHA ? trailing_edge : leading_edge;
    assign shift_edge    = CPHA ? leading_edge  : trailing_edge;
    assign cs_fall       = cs_old_reg && !cs_sync;
    assign cs_rise       = !cs_old_reg && cs_sync;

    // ------------------------------------------------------------------
    // Core state
    // ------------------------------------------------------------------
    state_t      state_reg,        state_next;
    logic [2:0]  bit_cnt_reg,      bit_cnt_next;
    logic [7:0]  rx_shift_reg,     rx_shift_next;
    logic [7:0]  tx_shift_reg,     tx_shift_next;
    logic [7:0]  tx_buf_reg,       tx_buf_next;
    logic        buf_full_reg,     buf_full_next;
    logic        load_pending_reg, load_pending_next;
    logic        miso_reg,         miso_next;
    logic        miso_en_reg,      miso_en_next;
    logic [7:0]  rx_byte_reg,      rx_byte_next;
    logic        rx_dv_reg,        rx_dv_next;
    logic        underrun_reg,     underrun_next;

    // Byte that a load point would move into the shift register this cycle.
    logic [7:0] load_val;
    logic [7:0] rx_completed;
    logic       do_load;

    assign load_val     = buf_full_reg ? tx_buf_reg : DEFAULT_TX;
    assign rx_completed = {rx_shift_reg[6:0], mosi_sync};

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_reg        <= ST_IDLE;
            bit_cnt_reg      <= '0;
            rx_shift_reg     <= '0;
            tx_shift_reg     <= '0;
            tx_buf_reg       <= '0;
            buf_full_reg     <= 1'b0;
            load_pending_reg <= 1'b0;
            miso_reg         <= 1'b0;
            miso_en_reg      <= 1'b0;
            rx_byte_reg      <= '0;
            rx_dv_reg        <= 1'b0;
            underrun_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            bit_cnt_reg      <= bit_cnt_next;
            rx_shift_reg     <= rx_shift_next;
            tx_shift_reg     <= tx_shift_next;
            tx_buf_reg       <= tx_buf_next;
            buf_full_reg     <= buf_full_next;
            load_pending_reg <= load_pending_next;
            miso_reg         <= miso_next;
            miso_en_reg      <= miso_en_next;
            rx_byte_reg      <= rx_byte_next;
            rx_dv_reg        <= rx_dv_next;
            underrun_reg     <= underrun_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        bit_cnt_next      = bit_cnt_reg;
        rx_shift_next     = rx_shift_reg;
        tx_shift_next     = tx_shift_reg;
        tx_buf_next       = tx_buf_reg;
        buf_full_next     = buf_full_reg;
        load_pending_next = load_pending_reg;
        miso_next         = miso_reg;
        miso_en_next      = miso_en_reg;
        rx_byte_next      = rx_byte_reg;
        rx_dv_next        = 1'b0;
        underrun_next     = 1'b0;
        do_load           = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // SCLK activity is ignored until the slave is selected.
                if (cs_fall) begin
                    state_next        = ST_ACTIVE;
                    bit_cnt_next      = '0;
                    rx_shift_next     = '0;
                    load_pending_next = 1'b0;
                    miso_en_next      = 1'b1;
                    do_load           = 1'b1;
                    if (!CPHA) begin
                        // MSB must be on the wire before the first leading edge.
                        miso_next     = load_val[7];
                        tx_shift_next = {load_val[6:0], 1'b0};
                    end else begin
                        // MSB goes out on the first leading (shift) edge.
                        tx_shift_next = load_val;
                    end
                end
            end

            ST_ACTIVE: begin
                if (cs_rise) begin
                    // Deselect wins over any coincident edge; partial RX is dropped.
                    state_next        = ST_IDLE;
                    bit_cnt_next      = '0;
                    rx_shift_next     = '0;
                    load_pending_next = 1'b0;
                    miso_en_next      = 1'b0;
                    miso_next         = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_next = rx_completed;
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            rx_byte_next      = rx_completed;
                            rx_dv_next        = 1'b1;
                            load_pending_next = 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        if (load_pending_reg) begin
                            // First shift edge of a new byte: fetch the next TX byte.
                            load_pending_next = 1'b0;
                            do_load           = 1'b1;
                            miso_next         = load_val[7];
                            tx_shift_next     = {load_val[6:0], 1'b0};
                        end else begin
                            miso_next     = tx_shift_reg[7];
                            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                        end
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Holding buffer. A load always empties it; a strobe is only taken
        // when it was already empty at the start of the cycle, so a strobe
        // coinciding with an underrun load refills it for the next load point.
        if (do_load) begin
            underrun_next = !buf_full_reg;
            buf_full_next = 1'b0;
        end
        if (i_TX_DV && !buf_full_reg) begin
            tx_buf_next   = i_TX_Byte;
            buf_full_next = 1'b1;
        end
    end

    assign o_SPI_MISO    = miso_reg;
    assign o_SPI_MISO_En = miso_en_reg;
    assign o_TX_Ready    = !buf_full_reg;
    assign o_TX_Underrun = underrun_reg;
    assign o_RX_Byte     = rx_byte_reg;
    assign o_RX_DV       = rx_dv_reg;

endmodule
